// File: rtl/weight_fetch_sched.sv
// Weight-fetch scheduler: streams G*WPG weight words per row pass from memory into the PE weight FIFO under credit control.
// Optional stall performance counter enabled by defining WFS_PERF_CNT_EN.
module weight_fetch_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int Wh         = 2,
    parameter int Ww         = 29,
    parameter int N          = 256,
    parameter int C          = 256,
    parameter int K          = 3,
    parameter int FIFO_DEPTH = (N + Wh - 1) / Wh + 8,
    parameter int MAX_OUT    = 4,
    parameter int ADDR_WIDTH = 20,
    parameter int PASS_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          cfg_base,
    input  logic [PASS_WIDTH-1:0]          cfg_passes,
    output logic                           busy,
    output logic                           done,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_gnt,
    input  logic                           mem_rvalid,
    input  logic [Wh*Ww*DATA_WIDTH-1:0]    mem_rdata,
    output logic                           weight_buffer_wren,
    output logic [Wh*Ww*DATA_WIDTH-1:0]    weight_buffer_din,
    input  logic                           weight_buffer_rden,
    input  logic                           weight_buffer_full,
    output logic                           err_overflow
`ifdef WFS_PERF_CNT_EN
    ,
    output logic [31:0]                    stall_cycles
`endif
);

    localparam int G     = (N + Wh - 1) / Wh;
    localparam int WPG   = (C * K * K + Ww - 1) / Ww;
    localparam int TOTAL = G * WPG;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int SW    = CW + 2;
    localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [IW-1:0] WIDX_LAST = IW'(TOTAL - 1);
    localparam logic [SW-1:0] DEPTH_S   = SW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXO_C    = CW'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   base_r, addr_nx;
    logic [PASS_WIDTH-1:0]   passes_r, pass_cnt, pass_nx;
    logic [IW-1:0]           widx, widx_nx;
    logic [CW-1:0]           occ, occ_nx, outstanding, out_nx;
    logic [SW-1:0]           sum_nx;
    logic                    req_nx, grant, rv_acc, last_grant, room_nx;

    assign grant      = mem_req & mem_gnt;
    // After reset nothing is outstanding, so late returns from an aborted run are dropped here.
    assign rv_acc     = mem_rvalid & (outstanding != '0);
    assign last_grant = grant && (widx == WIDX_LAST) &&
                        (({1'b0, pass_cnt} + (PASS_WIDTH + 1)'(1)) == {1'b0, passes_r});

    // Occupancy/outstanding bookkeeping and next-cycle issue room.
    always_comb begin
        occ_nx = occ;
        out_nx = outstanding;
        if (weight_buffer_wren && !weight_buffer_rden) begin
            occ_nx = occ + CW'(1);
        end else if (!weight_buffer_wren && weight_buffer_rden && (occ != '0)) begin
            occ_nx = occ - CW'(1);
        end else begin
            occ_nx = occ;
        end
        if (grant && !rv_acc) begin
            out_nx = outstanding + CW'(1);
        end else if (!grant && rv_acc) begin
            out_nx = outstanding - CW'(1);
        end else begin
            out_nx = outstanding;
        end
        // A word between rvalid and wren sits in the din register and still consumes a FIFO slot.
        sum_nx  = SW'(occ_nx) + SW'(out_nx) + SW'(rv_acc);
        room_nx = (sum_nx < DEPTH_S) && (out_nx < MAXO_C);
    end

    // Next-state, word index, pass counter and request decisions.
    always_comb begin
        state_nx = state;
        widx_nx  = widx;
        pass_nx  = pass_cnt;
        req_nx   = 1'b0;
        addr_nx  = mem_addr;
        case (state)
            IDLE: begin
                if (start) begin
                    widx_nx = '0;
                    pass_nx = '0;
                    if (cfg_passes == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = FETCH;
                        req_nx   = room_nx;
                        addr_nx  = cfg_base;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            FETCH: begin
                if (grant) begin
                    if (widx == WIDX_LAST) begin
                        widx_nx = '0;
                        pass_nx = pass_cnt + PASS_WIDTH'(1);
                    end else begin
                        widx_nx = widx + IW'(1);
                    end
                end else begin
                    widx_nx = widx;
                end
                if (last_grant) begin
                    state_nx = DRAIN;
                end else begin
                    req_nx  = (mem_req && !mem_gnt) ? 1'b1 : room_nx;
                    addr_nx = base_r + ADDR_WIDTH'(widx_nx);
                end
            end
            DRAIN: begin
                if (out_nx == '0) begin
                    state_nx = DONE;
                end else begin
                    state_nx = DRAIN;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            base_r             <= '0;
            passes_r           <= '0;
            widx               <= '0;
            pass_cnt           <= '0;
            occ                <= '0;
            outstanding        <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            mem_req            <= 1'b0;
            mem_addr           <= '0;
            weight_buffer_wren <= 1'b0;
            weight_buffer_din  <= '0;
            err_overflow       <= 1'b0;
        end else begin
            state              <= state_nx;
            widx               <= widx_nx;
            pass_cnt           <= pass_nx;
            occ                <= occ_nx;
            outstanding        <= out_nx;
            busy               <= (state_nx != IDLE);
            done               <= (state == DONE);
            mem_req            <= req_nx;
            mem_addr           <= addr_nx;
            weight_buffer_wren <= rv_acc;
            err_overflow       <= err_overflow | (weight_buffer_wren & weight_buffer_full);
            if (rv_acc) begin
                weight_buffer_din <= mem_rdata;
            end
            if ((state == IDLE) && start) begin
                base_r   <= cfg_base;
                passes_r <= cfg_passes;
            end
        end
    end

`ifdef WFS_PERF_CNT_EN
    logic [SW-1:0] inflight;
    logic          stall_now;
    assign inflight  = SW'(occ) + SW'(outstanding) + SW'(weight_buffer_wren);
    assign stall_now = (state == FETCH) && !mem_req &&
                       ((inflight >= DEPTH_S) || (outstanding >= MAXO_C));

    // Saturating count of FETCH cycles starved by credit or the outstanding limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
        end else if ((state == IDLE) && start) begin
            stall_cycles <= 32'd0;
        end else if (stall_now && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_weight_fetch_sched.sv
// Self-checking bench for weight_fetch_sched: memory/FIFO/consumer model, table-driven runs, random runs and corner sequences.
module tb_weight_fetch_sched;

    localparam int AW = 20, PW = 10, DEPTH = 4, MAXO = 2, TOTAL = 2, DW = 2 * 9 * 8;

    logic clk, rst, start, busy, done, mem_req, mem_gnt, mem_rvalid;
    logic [AW-1:0] cfg_base, mem_addr;
    logic [PW-1:0] cfg_passes;
    logic [DW-1:0] mem_rdata, weight_buffer_din;
    logic weight_buffer_wren, weight_buffer_rden, weight_buffer_full, err_overflow;
`ifdef WFS_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    weight_fetch_sched #(
        .DATA_WIDTH(8), .Wh(2), .Ww(9), .N(4), .C(1), .K(3),
        .FIFO_DEPTH(DEPTH), .MAX_OUT(MAXO), .ADDR_WIDTH(AW), .PASS_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_passes(cfg_passes),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .weight_buffer_wren(weight_buffer_wren), .weight_buffer_din(weight_buffer_din),
        .weight_buffer_rden(weight_buffer_rden), .weight_buffer_full(weight_buffer_full),
        .err_overflow(err_overflow)
`ifdef WFS_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; int due; } pend_t;
    typedef struct { int passes; logic [AW-1:0] base; int gnt_pct; int lat; int pop_pct; int exp_words; } vec_t;

    int checks = 0, failures = 0, cyc = 0;
    int gnt_pct = 100, pop_pct = 100, lat = 1;
    bit force_pop = 0, force_full = 0, hold_chk = 0;
    logic [AW-1:0] hold_addr, scen_base;
    logic [31:0] salt;
    pend_t pend_q[$];
    logic [AW-1:0] wq[$];
    int fifo_n = 0, gcount = 0, wcount = 0, done_cnt = 0, done_cyc = 0, last_rv_cyc = 0, stall_model = 0;

    function automatic logic [DW-1:0] dat(input logic [AW-1:0] a, input logic [31:0] s);
        logic [DW-1:0] d;
        d = '0;
        d[AW-1:0] = a;
        d[63:32] = s;
        d[DW-1:DW-AW] = ~a;
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock: account for what the FIFO/memory see at the coming edge, then drive the next cycle's inputs.
    task automatic tick();
        logic [AW-1:0] ea;
        if (hold_chk) begin
            chk("req_held", 32'(mem_req), 32'd1);
            chk("addr_held", 32'(mem_addr), 32'(hold_addr));
        end
        hold_chk  = (mem_req === 1'b1) && (mem_gnt === 1'b0) && !rst;
        hold_addr = mem_addr;
        if (weight_buffer_rden) fifo_n--;
        if ((weight_buffer_wren === 1'b1) && !rst) begin
            if (wq.size() == 0) chk("unexpected_wren", 32'd1, 32'd0);
            else begin
                ea = wq.pop_front();
                chkw("wr_data", weight_buffer_din, dat(ea, salt));
            end
            fifo_n++;
            wcount++;
        end
        if ((mem_req === 1'b1) && mem_gnt && !rst) begin
            ea = scen_base + AW'(gcount % TOTAL);
            chk("grant_addr", 32'(mem_addr), 32'(ea));
            gcount++;
            pend_q.push_back('{addr: mem_addr, due: cyc + lat});
            chk("credit", 32'((fifo_n + pend_q.size() + wq.size()) <= DEPTH), 32'd1);
            chk("max_out", 32'(pend_q.size() <= MAXO), 32'd1);
        end
        if ((busy === 1'b1) && (mem_req === 1'b0)) stall_model++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_gnt = ($urandom_range(99) < gnt_pct);
        if ((pend_q.size() > 0) && (pend_q[0].due <= cyc)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = dat(pend_q[0].addr, salt);
            wq.push_back(pend_q[0].addr);
            void'(pend_q.pop_front());
            last_rv_cyc = cyc;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        end
        if (force_pop) begin
            weight_buffer_rden = (fifo_n > 0);
            force_pop = 0;
        end else begin
            weight_buffer_rden = (fifo_n > 0) && ($urandom_range(99) < pop_pct);
        end
        weight_buffer_full = force_full || (fifo_n >= DEPTH);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic start_scen(input int passes, input logic [AW-1:0] base);
        gcount = 0; wcount = 0; done_cnt = 0; stall_model = 0;
        scen_base = base;
        salt = $urandom;
        cfg_base = base;
        cfg_passes = PW'(passes);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (passes != 0) chk("first_req", 32'(mem_req), 32'(fifo_n < DEPTH));
    endtask

    task automatic finish_scen(input int exp_words, input int exp_err, input string nm);
        int n = 0;
        while ((done_cnt == 0) && (n < 3000)) begin
            tick();
            n++;
        end
        chk({nm, "_done"}, done_cnt, 32'd1);
        chk({nm, "_grants"}, gcount, exp_words);
        chk({nm, "_writes"}, wcount, exp_words);
        chk({nm, "_busy_after"}, 32'(busy), 32'd0);
        chk({nm, "_err"}, 32'(err_overflow), 32'(exp_err));
        if (exp_words > 0) chk({nm, "_done_gap"}, done_cyc - last_rv_cyc, 32'd2);
    endtask

    task automatic clear_model();
        pend_q.delete();
        wq.delete();
        fifo_n = 0;
        hold_chk = 0;
        mem_rvalid = 1'b0;
        weight_buffer_rden = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        logic [AW-1:0] a0;
        int p;
        tbl[0] = '{3, 20'h00100, 100, 1, 100, 6};
        tbl[1] = '{5, 20'h003FF, 60, 3, 70, 10};
        tbl[2] = '{4, 20'hFFFFE, 100, 10, 100, 8};
        tbl[3] = '{7, 20'h12345, 40, 2, 30, 14};
        tbl[4] = '{1, 20'h00000, 80, 5, 50, 2};
        tbl[5] = '{2, 20'h55555, 100, 1, 20, 4};

        rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_passes = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        weight_buffer_rden = 1'b0; weight_buffer_full = 1'b0;
        salt = 32'd0; scen_base = '0; hold_addr = '0;
        idle(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wren", 32'(weight_buffer_wren), 32'd0);
        chkw("rst_din", weight_buffer_din, '0);
        chk("rst_err", 32'(err_overflow), 32'd0);
`ifdef WFS_PERF_CNT_EN
        chk("rst_stall", stall_cycles, 32'd0);
`endif
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            gnt_pct = tbl[i].gnt_pct; lat = tbl[i].lat; pop_pct = tbl[i].pop_pct;
            start_scen(tbl[i].passes, tbl[i].base);
            finish_scen(tbl[i].exp_words, 0, $sformatf("vec%0d", i));
            pop_pct = 100;
            idle(6);
        end

        for (int i = 0; i < 4; i++) begin
            p = $urandom_range(1, 6);
            gnt_pct = $urandom_range(30, 100); lat = $urandom_range(1, 8); pop_pct = $urandom_range(20, 100);
            start_scen(p, AW'($urandom));
            finish_scen(p * TOTAL, 0, $sformatf("rnd%0d", i));
            pop_pct = 100;
            idle(6);
        end
        gnt_pct = 100; lat = 1; pop_pct = 100;

        // cfg_passes=0 finishes without touching memory.
        start_scen(0, 20'h00050);
        chk("p0_busy", 32'(busy), 32'd1);
        chk("p0_req", 32'(mem_req), 32'd0);
        tick();
        chk("p0_done", 32'(done), 32'd1);
        chk("p0_busy_end", 32'(busy), 32'd0);
        chk("p0_grants", gcount, 32'd0);
        idle(4);

        // Back-pressure: no pops until the FIFO is full, then a single pop buys one request.
        pop_pct = 0;
        start_scen(10, 20'h00040);
        idle(20);
        chk("bp_req_low", 32'(mem_req), 32'd0);
        chk("bp_occ", fifo_n, 32'd4);
        chk("bp_outst", pend_q.size() + wq.size(), 32'd0);
        chk("bp_grants", gcount, 32'd4);
`ifdef WFS_PERF_CNT_EN
        chk("bp_stall", stall_cycles, stall_model);
`endif
        force_pop = 1;
        idle(8);
        chk("bp_one_more", gcount, 32'd5);
        chk("bp_req_low2", 32'(mem_req), 32'd0);
        chk("bp_occ2", fifo_n, 32'd4);
        pop_pct = 100;
        finish_scen(20, 0, "bp");
        idle(6);

        // Grant stall: request and address held while gnt is low.
        gnt_pct = 0;
        start_scen(2, 20'h04000);
        a0 = mem_addr;
        chk("gs_addr0", 32'(a0), 32'h04000);
        idle(5);
        chk("gs_req", 32'(mem_req), 32'd1);
        chk("gs_addr", 32'(mem_addr), 32'(a0));
        chk("gs_grants", gcount, 32'd0);
        gnt_pct = 100;
        finish_scen(4, 0, "gs");
        idle(6);

        // A second start while busy is ignored; the original base/passes are used.
        lat = 4;
        start_scen(3, 20'h00200);
        idle(3);
        cfg_base = 20'h00999; cfg_passes = PW'(1); start = 1'b1;
        tick();
        start = 1'b0;
        finish_scen(6, 0, "restart");
        lat = 1;
        idle(6);

        // Reset mid-FETCH, stale rvalid afterwards, then a clean rerun.
        lat = 6;
        start_scen(5, 20'h00777);
        idle(4);
        rst = 1'b1;
        tick();
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_req", 32'(mem_req), 32'd0);
        chk("mr_addr", 32'(mem_addr), 32'd0);
        chk("mr_wren", 32'(weight_buffer_wren), 32'd0);
        chkw("mr_din", weight_buffer_din, '0);
        rst = 1'b0;
        clear_model();
        mem_rvalid = 1'b1;
        tick();
        chk("mr_stale_rv", 32'(weight_buffer_wren), 32'd0);
        lat = 1;
        idle(3);
        start_scen(2, 20'h00777);
        finish_scen(4, 0, "post_rst");
        idle(4);

        // Writes while full set the sticky error; only reset clears it.
        force_full = 1;
        start_scen(1, 20'h00010);
        finish_scen(2, 1, "ovf");
        force_full = 0;
        idle(4);
        chk("ovf_sticky", 32'(err_overflow), 32'd1);
        rst = 1'b1;
        tick();
        chk("ovf_cleared", 32'(err_overflow), 32'd0);
        rst = 1'b0;
        clear_model();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_fetch_sched.md
# weight_fetch_sched

Weight-fetch scheduler for the PE array weight FIFO. It pulls weight words from an external weight memory over a request/grant/rvalid port. It pushes them into the `Wh*Ww*DATA_WIDTH` weight FIFO of the PE datain/buffer path, replaying the full output-channel group sequence once per row pass. Credit-based flow control guarantees that the FIFO is never overrun, without relying on the FIFO `full` flag.

## Interface
Parameters:
- DATA_WIDTH, 8, weight element width
- Wh, 2, PE array rows (output channels per group)
- Ww, 29, PE array columns (weights per row per word)
- N, 256, output channels; groups = ceil(N,Wh)/Wh
- C, 256, input channels
- K, 3, kernel size; words per group WPG = ceil(C*K*K,Ww)/Ww
- FIFO_DEPTH, ceil(N,Wh)/Wh+8, depth of the downstream weight FIFO
- MAX_OUT, 4, maximum outstanding memory requests (1..FIFO_DEPTH)
- ADDR_WIDTH, 20, weight memory word address width
- PASS_WIDTH, 10, width of pass count

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; ignored unless `busy`=0
- cfg_base  in  ADDR_WIDTH  word address of first weight word, latched on start
- cfg_passes  in  PASS_WIDTH  number of row passes, latched on start; 0 means finish immediately
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- mem_req  out  1  read request
- mem_addr  out  ADDR_WIDTH  read word address, valid with mem_req
- mem_gnt  in  1  request accepted this cycle when mem_req=1
- mem_rvalid  in  1  read data returned, in request order
- mem_rdata  in  Wh*Ww*DATA_WIDTH  returned weight word
- weight_buffer_wren  out  1  FIFO write strobe
- weight_buffer_din  out  Wh*Ww*DATA_WIDTH  FIFO write data
- weight_buffer_rden  in  1  FIFO pop by consumer (credit return)
- weight_buffer_full  in  1  FIFO full (checking only)
- err_overflow  out  1  sticky; set if wren occurs while full

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: on start, latch the config, zero the word index `widx` and pass counter, and go to FETCH.
  - If cfg_passes=0, go directly to DONE.
- FETCH: assert mem_req when credit > 0 and outstanding < MAX_OUT.
  - mem_addr = cfg_base + widx.
  - On mem_gnt, increment widx. When widx reaches G*WPG−1 at grant, wrap widx to 0 and increment the pass counter.
  - After the grant of the last word of the last pass, go to DRAIN.
- DRAIN: wait until outstanding=0 (all rvalid returned and written), then go to DONE.
- DONE: pulse done for one cycle, deassert busy, and go to IDLE.
- Credit accounting: credit = FIFO_DEPTH − occ − outstanding.
  - occ: +1 on wren, −1 on rden. Simultaneous +1 and −1 leaves occ unchanged.
  - outstanding: +1 on grant, −1 on rvalid.
  - Widths are clog2(FIFO_DEPTH+1) bits; credit never goes negative by construction.
- mem_req/mem_addr are held stable until mem_gnt; a request is never withdrawn.
- rden is counted in every state, including IDLE, so that a consumer draining after done is tracked; occ saturates at 0.
- err_overflow is set by wren∧full and cleared only by rst.
- start while busy=1 is ignored; it is not queued.

## Timing
- Reset values:
  - busy=0, done=0, mem_req=0, mem_addr=0, weight_buffer_wren=0, weight_buffer_din=0, err_overflow=0.
  - FSM=IDLE; occ, outstanding, widx and pass counter all 0.
- start→first mem_req: 1 cycle. mem_req is registered and rises the cycle after start, given credit > 0.
- Back-to-back issue: one grant per cycle is sustainable while credit and MAX_OUT allow.
- rvalid→wren: 1 registered cycle. weight_buffer_din = mem_rdata captured with rvalid.
- Last rvalid→done: 2 cycles (wren at +1, done at +2).
- rst asserted mid-operation: all state returns to reset values on the next edge. In-flight rvalids arriving after reset are ignored, because outstanding=0 gates acceptance.

## Configuration
- WFS_PERF_CNT_EN defined:
  - adds output `stall_cycles` (32 bits), counting FETCH cycles where mem_req=0 due to zero credit or MAX_OUT;
  - cleared on rst and on accepted start; saturates at all-ones.
- WFS_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.

## Test plan
- Nominal: N=4, Wh=2, C=1, K=3, Ww=9 (G=2, WPG=1), cfg_passes=3, cfg_base=0x100, mem_gnt tied 1, 1-cycle rvalid latency, consumer pops every cycle → addresses 0x100,0x101 repeated 3 times; 6 wren; done 2 cycles after last rvalid.
- Backpressure: FIFO_DEPTH=4, no rden until 4 writes → mem_req stays low with occ=4, outstanding=0; one rden pulse → exactly one more request; err_overflow stays 0.
- Outstanding limit: MAX_OUT=2, rvalid latency 10 cycles → never more than 2 grants before the first rvalid; data written in order.
- Grant stall: mem_gnt low for 5 cycles → mem_req and mem_addr held constant throughout; widx advances only on gnt.
- Edge cases: cfg_passes=0 → done 2 cycles after start, no mem_req. start while busy → ignored. rst mid-FETCH → all outputs at reset values next cycle; a subsequent start runs cleanly from cfg_base.
- With WFS_PERF_CNT_EN: backpressure scenario → stall_cycles equals the cycle count with occ=4 in FETCH.
